mdom_wvb_hdr_fifo_pack: RTL and testbench

MDOM_WVB_HDR_FIFO_PACK -- requirements
Module: mdom_wvb_hdr_fifo_pack

---
 rtl/mdom_wvb_hdr_fifo_pack.sv | 167 ++++++++++++++++
 tb/tb_mdom_wvb_hdr_fifo_pack.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdom_wvb_hdr_fifo_pack.sv
// Purpose : queue packed waveform-buffer event headers and serialize each one as NW words of P_OUT_W bits.
// Latency : hdr_wr in cycle N into an empty block with an idle serializer gives the sof word in cycle N+2.
// Backpres: a header held at o_dout stays stable while i_dout_rdy=0; writes into a full FIFO are dropped and counted.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_evt_ltc..i_local_coinc  header fields, captured when i_hdr_wr=1
//   i_hdr_wr             write one header this cycle
//   i_clr_ovfl           clear o_overflow and o_drop_cnt
//   o_dout/o_dout_valid/i_dout_rdy/o_dout_sof/o_dout_eof  word stream, valid/ready
//   o_hdr_cnt            headers held (FIFO + serializer)
//   o_full/o_empty       FIFO occupancy flags
//   o_overflow/o_drop_cnt  sticky drop flag and saturating drop count
module mdom_wvb_hdr_fifo_pack #(
    parameter int P_LTC_W  = 49,
    parameter int P_ADR_W  = 11,
    parameter int P_BSUM_W = 19,
    parameter int P_DEPTH  = 8,
    parameter int P_OUT_W  = 16,
    localparam int HDR_W   = P_LTC_W + 2*P_ADR_W + P_BSUM_W + 14,
    localparam int NW      = (HDR_W + P_OUT_W - 1) / P_OUT_W,
    localparam int CW      = $clog2(P_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [P_LTC_W-1:0]  i_evt_ltc,
    input  logic [P_ADR_W-1:0]  i_start_addr,
    input  logic [P_ADR_W-1:0]  i_stop_addr,
    input  logic [1:0]          i_trig_src,
    input  logic                i_cnst_run,
    input  logic [4:0]          i_pre_conf,
    input  logic                i_sync_rdy,
    input  logic [P_BSUM_W-1:0] i_bsum,
    input  logic [2:0]          i_bsum_len_sel,
    input  logic                i_bsum_valid,
    input  logic                i_local_coinc,
    input  logic                i_hdr_wr,
    input  logic                i_clr_ovfl,
    output logic [P_OUT_W-1:0]  o_dout,
    output logic                o_dout_valid,
    input  logic                i_dout_rdy,
    output logic                o_dout_sof,
    output logic                o_dout_eof,
    output logic [CW-1:0]       o_hdr_cnt,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_overflow,
    output logic [7:0]          o_drop_cnt
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int SW = NW * P_OUT_W;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_SEND  = 1'b1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(P_DEPTH);

    logic [HDR_W-1:0] r_mem [P_DEPTH];
    logic [CW-1:0]    r_wptr;
    logic [CW-1:0]    r_rptr;
    logic [0:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic [SW-1:0]    r_shift;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    logic [HDR_W-1:0] w_hdr;
    logic [CW-1:0]    w_occ;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_drop;
    logic             w_send;
    logic             w_xfer;
    logic             w_last;
    logic             w_pop;

    // LSB-first field order: evt_ltc sits at bit 0, local_coinc at the top.
    assign w_hdr = {i_local_coinc, i_bsum_valid, i_bsum_len_sel, i_bsum, i_sync_rdy,
                    i_pre_conf, i_cnst_run, i_trig_src, i_stop_addr, i_start_addr, i_evt_ltc};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_occ   = r_wptr - r_rptr;
    assign w_full  = (w_occ == DEPTH_C);
    assign w_empty = (w_occ == '0);

    // Full is judged on registered occupancy, so a same-cycle pop never makes room.
    assign w_push = i_hdr_wr && !w_full;
    assign w_drop = i_hdr_wr && w_full;

    assign w_send = (r_state == ST_SEND);
    assign w_xfer = w_send && i_dout_rdy;
    assign w_last = (r_idx == LAST_IDX);
    // Pop when idle, or on the eof transfer so the next header follows without a bubble.
    assign w_pop  = !w_empty && (!w_send || (w_xfer && w_last));

    // Header storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_hdr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Serializer: the current word always sits in the low P_OUT_W bits of the
    // shift register; each transfer shifts the next word down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_shift <= '0;
        end else if (w_pop) begin
            r_state <= ST_SEND;
            r_idx   <= '0;
            r_shift <= SW'(r_mem[r_rptr[AW-1:0]]);
        end else if (w_xfer && w_last) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_shift <= '0;
        end else if (w_xfer) begin
            r_idx   <= r_idx + 1'b1;
            r_shift <= r_shift >> P_OUT_W;
        end
    end

    // Clear wins over a same-cycle drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (i_clr_ovfl) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign o_dout       = r_shift[P_OUT_W-1:0];
    assign o_dout_valid = w_send;
    assign o_dout_sof   = w_send && (r_idx == '0);
    assign o_dout_eof   = w_send && w_last;
    assign o_hdr_cnt    = w_occ + CW'(w_send);
    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_overflow   = r_overflow;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_mdom_wvb_hdr_fifo_pack.sv
// Purpose : self-checking bench for mdom_wvb_hdr_fifo_pack, default build plus a 32-bit/depth-4 build.
// Latency : checks sof at N+2 after a write into an idle block.
// Backpres: checks word stability under dout_rdy=0 and drop accounting on a full FIFO.
module tb_mdom_wvb_hdr_fifo_pack;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Default build stimulus/response
    logic [103:0] h1;
    logic         wr1, clr1, rdy1;
    logic [15:0]  dout1;
    logic         vld1, sof1, eof1, full1, empty1, ovf1;
    logic [3:0]   cnt1;
    logic [7:0]   drop1;

    // 32-bit output, depth-4 build
    logic [103:0] h2;
    logic         wr2, clr2, rdy2;
    logic [31:0]  dout2;
    logic         vld2, sof2, eof2, full2, empty2, ovf2;
    logic [2:0]   cnt2;
    logic [7:0]   drop2;

    exp_t q1[$];
    exp_t q2[$];
    int   wrote2 = 0;
    int   eofs2  = 0;
    logic done2  = 1'b0;

    // Port slices follow the header bit map, LSB first.
    mdom_wvb_hdr_fifo_pack u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_evt_ltc(h1[48:0]), .i_start_addr(h1[59:49]), .i_stop_addr(h1[70:60]),
        .i_trig_src(h1[72:71]), .i_cnst_run(h1[73]), .i_pre_conf(h1[78:74]),
        .i_sync_rdy(h1[79]), .i_bsum(h1[98:80]), .i_bsum_len_sel(h1[101:99]),
        .i_bsum_valid(h1[102]), .i_local_coinc(h1[103]),
        .i_hdr_wr(wr1), .i_clr_ovfl(clr1),
        .o_dout(dout1), .o_dout_valid(vld1), .i_dout_rdy(rdy1),
        .o_dout_sof(sof1), .o_dout_eof(eof1), .o_hdr_cnt(cnt1),
        .o_full(full1), .o_empty(empty1), .o_overflow(ovf1), .o_drop_cnt(drop1)
    );

    mdom_wvb_hdr_fifo_pack #(.P_DEPTH(4), .P_OUT_W(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_evt_ltc(h2[48:0]), .i_start_addr(h2[59:49]), .i_stop_addr(h2[70:60]),
        .i_trig_src(h2[72:71]), .i_cnst_run(h2[73]), .i_pre_conf(h2[78:74]),
        .i_sync_rdy(h2[79]), .i_bsum(h2[98:80]), .i_bsum_len_sel(h2[101:99]),
        .i_bsum_valid(h2[102]), .i_local_coinc(h2[103]),
        .i_hdr_wr(wr2), .i_clr_ovfl(clr2),
        .o_dout(dout2), .o_dout_valid(vld2), .i_dout_rdy(rdy2),
        .o_dout_sof(sof2), .o_dout_eof(eof2), .o_hdr_cnt(cnt2),
        .o_full(full2), .o_empty(empty2), .o_overflow(ovf2), .o_drop_cnt(drop2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [103:0] rand_hdr();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[103:0];
    endfunction

    task automatic push1(input logic [103:0] h);
        logic [111:0] p;
        exp_t e;
        p = {8'h00, h};
        for (int i = 0; i < 7; i++) begin
            e.d = {16'h0000, p[i*16 +: 16]};
            e.s = (i == 0);
            e.e = (i == 6);
            q1.push_back(e);
        end
    endtask

    task automatic push2(input logic [103:0] h);
        logic [127:0] p;
        exp_t e;
        p = {24'h000000, h};
        for (int i = 0; i < 4; i++) begin
            e.d = p[i*32 +: 32];
            e.s = (i == 0);
            e.e = (i == 3);
            q2.push_back(e);
        end
    endtask

    // Scoreboard monitors: compare every transfer, and require a stalled word to hold.
    logic        pv1 = 1'b0, pr1 = 1'b0, pv2 = 1'b0, pr2 = 1'b0;
    logic [15:0] pd1;
    logic [31:0] pd2;
    logic [1:0]  pf1, pf2;
    exp_t        e1, e2;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv1 = 1'b0;
        end else begin
            if (pv1 && !pr1) begin
                chk("stall1_vld", 64'(vld1), 64'd1);
                chk("stall1_dat", 64'(dout1), 64'(pd1));
                chk("stall1_flags", 64'({sof1, eof1}), 64'(pf1));
            end
            if (!vld1) begin
                chk("idle1_flags", 64'({sof1, eof1}), 64'd0);
            end else if (rdy1) begin
                if (q1.size() == 0) begin
                    chk("sb1_unexpected_vld", 64'(vld1), 64'd0);
                end else begin
                    e1 = q1.pop_front();
                    chk("sb1_dat", 64'(dout1), 64'(e1.d[15:0]));
                    chk("sb1_sof", 64'(sof1), 64'(e1.s));
                    chk("sb1_eof", 64'(eof1), 64'(e1.e));
                end
            end
            pv1 = vld1; pr1 = rdy1; pd1 = dout1; pf1 = {sof1, eof1};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pv2 = 1'b0;
        end else begin
            if (pv2 && !pr2) begin
                chk("stall2_vld", 64'(vld2), 64'd1);
                chk("stall2_dat", 64'(dout2), 64'(pd2));
                chk("stall2_flags", 64'({sof2, eof2}), 64'(pf2));
            end
            if (!vld2) begin
                chk("idle2_flags", 64'({sof2, eof2}), 64'd0);
            end else if (rdy2) begin
                if (q2.size() == 0) begin
                    chk("sb2_unexpected_vld", 64'(vld2), 64'd0);
                end else begin
                    e2 = q2.pop_front();
                    chk("sb2_dat", 64'(dout2), 64'(e2.d));
                    chk("sb2_sof", 64'(sof2), 64'(e2.s));
                    chk("sb2_eof", 64'(eof2), 64'(e2.e));
                    if (eof2) eofs2++;
                end
            end
            pv2 = vld2; pr2 = rdy2; pd2 = dout2; pf2 = {sof2, eof2};
        end
    end

    task automatic drain1();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (q1.size() == 0 && !vld1) break;
        end
        chk("drain1_q", 64'(q1.size()), 64'd0);
        chk("drain1_vld", 64'(vld1), 64'd0);
        chk("drain1_cnt", 64'(cnt1), 64'd0);
    endtask

    task automatic drain2();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (q2.size() == 0 && !vld2) break;
        end
        chk("drain2_q", 64'(q2.size()), 64'd0);
        chk("drain2_vld", 64'(vld2), 64'd0);
        chk("drain2_cnt", 64'(cnt2), 64'd0);
    endtask

    // Single write into an idle block; ends at the negedge of cycle N+2 (word 0 showing).
    task automatic lat_hdr(input logic [103:0] h, input string tg);
        @(posedge clk); #1;
        h1 = h; wr1 = 1'b1; push1(h);
        @(posedge clk); #1;
        wr1 = 1'b0; h1 = '0;
        @(negedge clk);
        chk({tg, "_n1_vld"}, 64'(vld1), 64'd0);
        @(negedge clk);
        chk({tg, "_n2_vld"}, 64'(vld1), 64'd1);
        chk({tg, "_n2_sof"}, 64'(sof1), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [103:0] h, ha, hb, hc;
        logic [15:0]  cap [7];

        rst_n = 1'b0;
        h1 = '0; wr1 = 1'b0; clr1 = 1'b0; rdy1 = 1'b1;
        h2 = '0; wr2 = 1'b0; clr2 = 1'b0; rdy2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 64'(vld1), 64'd0);
        chk("rst_dout", 64'(dout1), 64'd0);
        chk("rst_flags", 64'({sof1, eof1}), 64'd0);
        chk("rst_cnt", 64'(cnt1), 64'd0);
        chk("rst_full", 64'(full1), 64'd0);
        chk("rst_empty", 64'(empty1), 64'd1);
        chk("rst_ovf", 64'(ovf1), 64'd0);
        chk("rst_drop", 64'(drop1), 64'd0);
        chk("rst2_empty", 64'(empty2), 64'd1);
        rst_n = 1'b1;

        // Directed single header with known field values
        h = '0;
        h[48:0]  = 49'h1_2345_6789_ABCD;
        h[59:49] = 11'h7FF;
        lat_hdr(h, "lat");
        cap[0] = dout1;
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            cap[i] = dout1;
        end
        chk("w0", 64'(cap[0]), 64'h0000_0000_0000_ABCD);
        chk("w3_ltc48", 64'(cap[3][0]), 64'd1);
        chk("w3_start", 64'(cap[3][11:1]), 64'h7FF);
        chk("w6_pad", 64'(cap[6][15:8]), 64'd0);
        drain1();

        // Back-to-back headers must stream without a bubble
        @(posedge clk); #1;
        h = rand_hdr(); h1 = h; wr1 = 1'b1; push1(h);
        @(posedge clk); #1;
        h = rand_hdr(); h1 = h; push1(h);
        @(posedge clk); #1;
        wr1 = 1'b0;
        begin
            int run;
            run = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (vld1) run++;
                else if (run > 0) break;
            end
            chk("b2b_run", 64'(run), 64'd14);
        end
        drain1();

        // Fill while stalled: 9 held, tenth dropped
        @(posedge clk); #1;
        rdy1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            h = rand_hdr(); h1 = h; wr1 = 1'b1;
            if (i < 9) push1(h);
            @(posedge clk); #1;
        end
        wr1 = 1'b0;
        @(negedge clk);
        chk("fill_cnt", 64'(cnt1), 64'd9);
        chk("fill_full", 64'(full1), 64'd1);
        chk("fill_ovf", 64'(ovf1), 64'd1);
        chk("fill_drop", 64'(drop1), 64'd1);
        @(posedge clk); #1;
        rdy1 = 1'b1;
        drain1();

        // Drop counter saturation and clear-versus-drop priority
        @(posedge clk); #1;
        clr1 = 1'b1;
        @(posedge clk); #1;
        clr1 = 1'b0;
        @(negedge clk);
        chk("clr_ovf", 64'(ovf1), 64'd0);
        chk("clr_drop", 64'(drop1), 64'd0);
        @(posedge clk); #1;
        rdy1 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            h = rand_hdr(); h1 = h; wr1 = 1'b1; push1(h);
            @(posedge clk); #1;
        end
        h1 = rand_hdr();
        repeat (260) begin
            @(posedge clk); #1;
        end
        wr1 = 1'b0;
        @(negedge clk);
        chk("sat_drop", 64'(drop1), 64'd255);
        chk("sat_ovf", 64'(ovf1), 64'd1);
        chk("sat_cnt", 64'(cnt1), 64'd9);
        @(posedge clk); #1;
        wr1 = 1'b1; clr1 = 1'b1;
        @(posedge clk); #1;
        wr1 = 1'b0; clr1 = 1'b0;
        @(negedge clk);
        chk("clrdrop_ovf", 64'(ovf1), 64'd0);
        chk("clrdrop_drop", 64'(drop1), 64'd0);
        chk("clrdrop_full", 64'(full1), 64'd1);
        @(posedge clk); #1;
        rdy1 = 1'b1;
        drain1();

        // Reset in the middle of word 3 with two headers queued
        @(posedge clk); #1;
        ha = rand_hdr(); h1 = ha; wr1 = 1'b1; push1(ha);
        @(posedge clk); #1;
        hb = rand_hdr(); h1 = hb; push1(hb);
        @(posedge clk); #1;
        hc = rand_hdr(); h1 = hc; push1(hc);
        @(posedge clk); #1;
        wr1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("prerst_w3", 64'(dout1), 64'(ha[63:48]));
        chk("prerst_cnt", 64'(cnt1), 64'd3);
        rst_n = 1'b0;
        #1;
        q1.delete();
        chk("midrst_vld", 64'(vld1), 64'd0);
        chk("midrst_dout", 64'(dout1), 64'd0);
        chk("midrst_flags", 64'({sof1, eof1}), 64'd0);
        chk("midrst_empty", 64'(empty1), 64'd1);
        chk("midrst_cnt", 64'(cnt1), 64'd0);
        @(posedge clk); #1;
        h1 = rand_hdr(); wr1 = 1'b1;
        @(posedge clk); #1;
        wr1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_empty", 64'(empty1), 64'd1);
        chk("postrst_cnt", 64'(cnt1), 64'd0);
        lat_hdr(rand_hdr(), "rstlat");
        drain1();

        // 32-bit/depth-4 build under random ready
        fork
            begin
                for (int k = 0; k < 20000 && !done2; k++) begin
                    @(posedge clk); #1;
                    rdy2 = 1'($urandom_range(0, 1));
                end
                rdy2 = 1'b1;
            end
        join_none
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 2000 && (wrote2 - eofs2) >= 4; g++) begin
                @(posedge clk); #1;
            end
            chk("sb2_room", 64'((wrote2 - eofs2) < 4), 64'd1);
            h = rand_hdr(); h2 = h; wr2 = 1'b1; push2(h); wrote2++;
            @(posedge clk); #1;
            wr2 = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        done2 = 1'b1;
        drain2();
        chk("p2_drop", 64'(drop2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
